cond_unit_pipe: RTL and testbench
=================================

# cond_unit_pipe

Multi-lane, registered successor to the single-lane ARM condition checker. It owns the architectural NZCV flag register and evaluates up to LANES condition codes per beat in program order, forwarding each lane's flag update to the next lane. It gates every flag write with that lane's own CondEx. It sits between decode/ALU and writeback, behind a valid/ready handshake, with one cycle of latency.

## Interface
- LANES, 2: instructions per beat, 1..4.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_lane_en  in  LANES  lane holds a real instruction.
- in_cond  in  LANES×4  condition field per lane; lane 0 is oldest.
- in_flagw  in  LANES×2  per-lane flag write: bit1 = NZ, bit0 = CV.
- in_alu_flags  in  LANES×4  ALU {N,Z,C,V} per lane.
- flags_wr_en  in  1  direct flag load (MSR path).
- flags_wr_data  in  4  {N,Z,C,V} for the direct load.
- flush  in  1  drop the pending output beat.
- out_valid  out  1  registered result valid.
- out_ready  in  1  consumer accepts.
- out_condex  out  LANES  per-lane CondEx.
- out_undef  out  LANES  cond = 1111 seen (macro only; otherwise tied 0).
- flags_q  out  4  architectural {N,Z,C,V}.

## Operation
- Condition decode for codes 0000..1110 is unchanged: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - ge = (N == V).
  - 1111 (NV) always evaluates to 0. It never yields X.
- Lane chain on accept, with f0 = flags_q:
  - condex_i = in_lane_en[i] & eval(in_cond[i], f_i).
  - f_{i+1}.NZ = (in_flagw[i][1] & condex_i) ? alu_i.NZ : f_i.NZ.
  - f_{i+1}.CV = (in_flagw[i][0] & condex_i) ? alu_i.CV : f_i.CV.
- flags_q <= f_LANES at accept. Flags commit at acceptance, not at output handshake.
- A disabled lane passes f_i through unchanged and produces condex = 0.
- in_ready = ~flags_wr_en & ~flush & (~out_valid | out_ready).
- flags_wr_en loads flags_q <= flags_wr_data. It blocks acceptance that cycle, so the two never collide.
- Output register:
  - Loads condex/undef on accept and sets out_valid.
  - Clears out_valid on output handshake with no new accept.
  - Back-to-back accept + output handshake in the same cycle keeps out_valid = 1 with the new data.
- Flush clears out_valid next edge. Flags are not rolled back.
- Output data is held stable while out_valid & ~out_ready.

## Timing
- Reset (async assert, sync release): flags_q = 0000, out_valid = 0, out_condex = 0, out_undef = 0.
- Asserting reset mid-beat discards the beat. Flag updates from that beat do not survive.
- Latency: accept at edge k, result visible after edge k, with out_valid high in cycle k+1.
- Throughput: one beat per cycle while out_ready = 1.
- Lane i forwarding is combinational within the beat. The critical path is LANES chained evaluations.
- A beat accepted immediately after another sees flags_q already updated, with no bubble.

## Configuration
- COND_NV_UNDEF_EN, when defined:
  - out_undef[i] = in_lane_en[i] & (in_cond[i] == 4'b1111), registered with out_condex.
  - condex stays 0 for that lane.
- When not defined: out_undef is a constant 0, and no register is built for it.

## Structure
- Package cond_pkg holds:
  - cond_e enum of the 15 codes plus NV.
  - flags_t packed struct {n, z, c, v}.
  - Localparams FLAGW_NZ = 1 and FLAGW_CV = 0.
- Sub-module cond_eval: combinational (cond_e, flags_t) -> condex. It is instantiated once per lane in a generate loop.
- The top holds the chain, flag register, output register and handshake.

## Test plan
- Reset, then one beat with LANES = 2, flags 0000, lane0 CMP-like (AL, flagw = 11, alu = 0100), lane1 EQ:
  - condex = 11, flags_q = 0100 after the accept edge.
- Lane0 NE with Z = 1, flagw = 11, alu = 1000, then lane1 MI:
  - lane0 suppressed, so no flag write.
  - lane1 sees N = 0, giving condex = 00.
  - flags_q unchanged.
- out_ready = 0 for 3 cycles with in_valid held high:
  - in_ready = 0.
  - out_condex stable.
  - flags_q unchanged until the next accept.
- flags_wr_en = 1, data 0011, same cycle as in_valid:
  - beat not accepted.
  - flags_q = 0011.
  - the beat accepted next cycle evaluates GE against 0011, giving 0 (N = 0, V = 1).
- flush with out_valid = 1: out_valid = 0 next cycle, flags_q keeps the committed value.
- cond = 1111 on lane1:
  - condex[1] = 0.
  - out_undef[1] = 1 only with COND_NV_UNDEF_EN defined; otherwise 0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the pipelined ARM condition unit: condition codes, NZCV flags
// and the bit positions of the per-lane flag-write field.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_pipe_if.sv
// Handshake and data bundle of cond_unit_pipe; the producer/consumer side uses
// modport master, the condition unit uses modport slave.
interface cond_unit_pipe_if #(parameter int LANES = 2);

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_en;
  logic [LANES-1:0][3:0] in_cond;
  logic [LANES-1:0][1:0] in_flagw;
  logic [LANES-1:0][3:0] in_alu_flags;
  logic                  flags_wr_en;
  logic [3:0]            flags_wr_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_condex;
  logic [LANES-1:0]      out_undef;
  logic [3:0]            flags_q;

  modport master (
    output in_valid, in_lane_en, in_cond, in_flagw, in_alu_flags,
           flags_wr_en, flags_wr_data, flush, out_ready,
    input  in_ready, out_valid, out_condex, out_undef, flags_q
  );

  modport slave (
    input  in_valid, in_lane_en, in_cond, in_flagw, in_alu_flags,
           flags_wr_en, flags_wr_data, flush, out_ready,
    output in_ready, out_valid, out_condex, out_undef, flags_q
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational evaluation of one ARM condition code against a set of NZCV flags.
module cond_eval
  import cond_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_condex
);

  logic w_ge;

  assign w_ge = (i_flags.n == i_flags.v);

  always_comb begin
    o_condex = 1'b0;
    case (i_cond)
      COND_EQ: o_condex = i_flags.z;
      COND_NE: o_condex = ~i_flags.z;
      COND_CS: o_condex = i_flags.c;
      COND_CC: o_condex = ~i_flags.c;
      COND_MI: o_condex = i_flags.n;
      COND_PL: o_condex = ~i_flags.n;
      COND_VS: o_condex = i_flags.v;
      COND_VC: o_condex = ~i_flags.v;
      COND_HI: o_condex = i_flags.c & ~i_flags.z;
      COND_LS: o_condex = ~i_flags.c | i_flags.z;
      COND_GE: o_condex = w_ge;
      COND_LT: o_condex = ~w_ge;
      COND_GT: o_condex = ~i_flags.z & w_ge;
      COND_LE: o_condex = i_flags.z | ~w_ge;
      COND_AL: o_condex = 1'b1;
      // NV never executes
      default: o_condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Multi-lane registered condition unit owning the NZCV register; flag updates
// chain lane to lane within a beat. Optional macro COND_NV_UNDEF_EN reports cond=1111.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic clk,
  input  logic reset_n,
  cond_unit_pipe_if.slave bus
);

  flags_t           r_flags;
  logic             r_out_valid;
  logic [LANES-1:0] r_condex;
  logic [LANES-1:0] w_condex;
  flags_t           w_f_last;
  logic             w_accept;

  assign bus.in_ready = ~bus.flags_wr_en & ~bus.flush & (~r_out_valid | bus.out_ready);
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Lane i sees the flags as left by lanes 0..i-1 of the same beat.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    flags_t w_fi;
    flags_t w_fo;
    flags_t w_alu;
    logic   w_eval;

    if (g == 0) begin : g_first
      assign w_fi = r_flags;
    end else begin : g_rest
      assign w_fi = g_lane[g-1].w_fo;
    end

    assign w_alu = bus.in_alu_flags[g];

    cond_eval u_eval (
      .i_cond   (cond_e'(bus.in_cond[g])),
      .i_flags  (w_fi),
      .o_condex (w_eval)
    );

    assign w_condex[g] = bus.in_lane_en[g] & w_eval;

    assign w_fo.n = (bus.in_flagw[g][FLAGW_NZ] & w_condex[g]) ? w_alu.n : w_fi.n;
    assign w_fo.z = (bus.in_flagw[g][FLAGW_NZ] & w_condex[g]) ? w_alu.z : w_fi.z;
    assign w_fo.c = (bus.in_flagw[g][FLAGW_CV] & w_condex[g]) ? w_alu.c : w_fi.c;
    assign w_fo.v = (bus.in_flagw[g][FLAGW_CV] & w_condex[g]) ? w_alu.v : w_fi.v;
  end

  assign w_f_last = g_lane[LANES-1].w_fo;

  // Flags commit on accept, independent of when the consumer takes the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_condex    <= '0;
    end else begin
      if (bus.flags_wr_en) begin
        r_flags <= flags_t'(bus.flags_wr_data);
      end else if (w_accept) begin
        r_flags <= w_f_last;
      end

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_condex    <= w_condex;
      end else if (bus.flush | bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef COND_NV_UNDEF_EN
  logic [LANES-1:0] r_undef;
  logic [LANES-1:0] w_undef;

  for (genvar u = 0; u < LANES; u++) begin : g_undef
    assign w_undef[u] = bus.in_lane_en[u] & (bus.in_cond[u] == 4'b1111);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_undef <= '0;
    end else if (w_accept) begin
      r_undef <= w_undef;
    end
  end

  assign bus.out_undef = r_undef;
`else
  assign bus.out_undef = '0;
`endif

  assign bus.out_valid  = r_out_valid;
  assign bus.out_condex = r_condex;
  assign bus.flags_q    = r_flags;

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed self-checking bench for cond_unit_pipe with LANES = 2; expected
// out_undef follows COND_NV_UNDEF_EN.
module tb_cond_unit_pipe;

  localparam int LANES = 2;

`ifdef COND_NV_UNDEF_EN
  localparam logic [1:0] EXP_UNDEF_NV = 2'b10;
`else
  localparam logic [1:0] EXP_UNDEF_NV = 2'b00;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  cond_unit_pipe_if #(.LANES(LANES)) bus ();

  cond_unit_pipe #(.LANES(LANES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic v, input logic [1:0] en, input logic [7:0] cond,
                          input logic [3:0] flagw, input logic [7:0] alu);
    bus.in_valid     = v;
    bus.in_lane_en   = en;
    bus.in_cond      = cond;
    bus.in_flagw     = flagw;
    bus.in_alu_flags = alu;
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    bus.flags_wr_en   = 1'b0;
    bus.flags_wr_data = 4'h0;
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b1;
    set_beat(1'b0, 2'b00, 8'h00, 4'h0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (bus.flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", bus.flags_q); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_condex !== 2'b00) begin n_fail++; $display("FAIL reset_condex got %b exp 00", bus.out_condex); end
    n_checks++; if (bus.out_undef !== 2'b00) begin n_fail++; $display("FAIL reset_undef got %b exp 00", bus.out_undef); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_cmp_eq();
    @(negedge clk);
    // lane0 AL writes NZCV=0100, lane1 EQ must see Z=1 forwarded
    set_beat(1'b1, 2'b11, {4'h0, 4'hE}, {2'b00, 2'b11}, {4'h0, 4'h4});
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL cmp_out_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_condex !== 2'b11) begin n_fail++; $display("FAIL cmp_condex got %b exp 11", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b0100) begin n_fail++; $display("FAIL cmp_flags got %b exp 0100", bus.flags_q); end
  endtask

  task automatic test_ne_suppress();
    @(negedge clk);
    set_beat(1'b1, 2'b11, {4'h4, 4'h1}, {2'b00, 2'b11}, {4'h0, 4'h8});
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ne_out_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_condex !== 2'b00) begin n_fail++; $display("FAIL ne_condex got %b exp 00", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b0100) begin n_fail++; $display("FAIL ne_flags got %b exp 0100", bus.flags_q); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    // lane0 disabled (AL would write flags), lane1 AL
    set_beat(1'b1, 2'b10, {4'hE, 4'hE}, {2'b00, 2'b11}, {4'h0, 4'hF});
    @(posedge clk); #1;
    n_checks++; if (bus.out_condex !== 2'b10) begin n_fail++; $display("FAIL dis_condex got %b exp 10", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b0100) begin n_fail++; $display("FAIL dis_flags got %b exp 0100", bus.flags_q); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_beat(1'b1, 2'b11, {4'h6, 4'hE}, {2'b00, 2'b11}, {4'h0, 4'h9});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d] got %b exp 1", i, bus.out_valid); end
      n_checks++; if (bus.out_condex !== 2'b10) begin n_fail++; $display("FAIL stall_condex[%0d] got %b exp 10", i, bus.out_condex); end
      n_checks++; if (bus.flags_q !== 4'b0100) begin n_fail++; $display("FAIL stall_flags[%0d] got %b exp 0100", i, bus.flags_q); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    // lane0 AL writes 1001, lane1 VS sees V=1
    n_checks++; if (bus.out_condex !== 2'b11) begin n_fail++; $display("FAIL release_condex got %b exp 11", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b1001) begin n_fail++; $display("FAIL release_flags got %b exp 1001", bus.flags_q); end
  endtask

  task automatic test_flags_wr();
    @(negedge clk);
    bus.flags_wr_en   = 1'b1;
    bus.flags_wr_data = 4'b0011;
    set_beat(1'b1, 2'b11, {4'hB, 4'hA}, {2'b00, 2'b00}, {4'h0, 4'h0});
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL wr_in_ready got %b exp 0", bus.in_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.flags_q !== 4'b0011) begin n_fail++; $display("FAIL wr_flags got %b exp 0011", bus.flags_q); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wr_out_valid got %b exp 0", bus.out_valid); end
    @(negedge clk);
    bus.flags_wr_en = 1'b0;
    @(posedge clk); #1;
    // GE against N=0,V=1 fails, LT passes
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ge_out_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_condex !== 2'b10) begin n_fail++; $display("FAIL ge_condex got %b exp 10", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b0011) begin n_fail++; $display("FAIL ge_flags got %b exp 0011", bus.flags_q); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.flags_q !== 4'b0011) begin n_fail++; $display("FAIL flush_flags got %b exp 0011", bus.flags_q); end
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic test_nv();
    @(negedge clk);
    set_beat(1'b1, 2'b11, {4'hF, 4'hE}, {2'b11, 2'b00}, {4'hF, 4'h0});
    @(posedge clk); #1;
    n_checks++; if (bus.out_condex !== 2'b01) begin n_fail++; $display("FAIL nv_condex got %b exp 01", bus.out_condex); end
    n_checks++; if (bus.out_undef !== EXP_UNDEF_NV) begin n_fail++; $display("FAIL nv_undef got %b exp %b", bus.out_undef, EXP_UNDEF_NV); end
    n_checks++; if (bus.flags_q !== 4'b0011) begin n_fail++; $display("FAIL nv_flags got %b exp 0011", bus.flags_q); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    // lane0 AL writes NZ=10 only, lane1 MI sees N=1
    set_beat(1'b1, 2'b11, {4'h4, 4'hE}, {2'b00, 2'b10}, {4'h0, 4'h8});
    @(posedge clk); #1;
    n_checks++; if (bus.out_condex !== 2'b11) begin n_fail++; $display("FAIL b2b_a_condex got %b exp 11", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b1011) begin n_fail++; $display("FAIL b2b_a_flags got %b exp 1011", bus.flags_q); end
    @(negedge clk);
    set_beat(1'b1, 2'b11, {4'hA, 4'h5}, {2'b00, 2'b00}, {4'h0, 4'h0});
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_b_out_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_condex !== 2'b10) begin n_fail++; $display("FAIL b2b_b_condex got %b exp 10", bus.out_condex); end
    n_checks++; if (bus.flags_q !== 4'b1011) begin n_fail++; $display("FAIL b2b_b_flags got %b exp 1011", bus.flags_q); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_beat(1'b1, 2'b01, {4'h0, 4'hE}, {2'b00, 2'b11}, {4'h0, 4'hF});
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_valid got %b exp 0", bus.out_valid); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.flags_q !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags got %b exp 0000", bus.flags_q); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b exp 0", bus.out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cmp_eq();
    test_ne_suppress();
    test_stall();
    test_flags_wr();
    test_flush();
    test_nv();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
